// File: rtl/afifo_pkg.sv
// Shared state type, parameter defaults and width helper for the FIFO read scheduler.
// No logic of its own: types and constant functions only.
// Imported by the arbiter and the scheduler top.
package afifo_pkg;

  localparam int NUM_REQ_DEFAULT   = 4;
  localparam int MAX_BURST_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_TAIL  = 2'd2
  } sched_state_e;

  // Ceiling log2; values of 0 or 1 give 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after the pointer, wrapping, as a one-hot grant.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter
  import afifo_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int PTR_W   = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  int               sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk the requesters starting at the pointer and keep the first one that is set.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr_i) + i;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      idx = PTR_W'(sum);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/afifo_rd_sched.sv
// Shares one async-FIFO read port among NUM_REQ consumers in round-robin bursts of up to MAX_BURST reads.
// Latency: read enable is combinational; each read's data strobe follows one cycle later.
// Backpressure: reads stop the same cycle the FIFO goes empty or the owner drops its request.
module afifo_rd_sched
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = NUM_REQ_DEFAULT,
  parameter int MAX_BURST  = MAX_BURST_DEFAULT
) (
  input  logic                  RClk,
  input  logic                  PresetFull,
  input  logic                  Fifo_Empty,
  input  logic [DATA_WIDTH-1:0] Fifo_Data,
  output logic                  Fifo_ReadEn,
  input  logic [NUM_REQ-1:0]    Req_in,
  output logic [NUM_REQ-1:0]    Grant_out,
  output logic [NUM_REQ-1:0]    Valid_out,
  output logic [DATA_WIDTH-1:0] Data_out
);

  localparam int               PTR_W    = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
  localparam int               CNT_W    = clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(NUM_REQ - 1);

  sched_state_e        state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]    gidx_q, gidx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  valid_q;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [PTR_W-1:0]    arb_idx;
  logic                rd_en;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req_i (Req_in),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  // Index of the arbiter's pick, kept so the pointer can step past the owner on release.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        arb_idx = PTR_W'(i);
      end
    end
  end

  // Burst sequencing: arbitrate in IDLE, read while allowed in BURST, one drain cycle in TAIL.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    rd_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (!Fifo_Empty && (Req_in != '0)) begin
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        rd_en = !Fifo_Empty && ((Req_in & grant_q) != '0) && (cnt_q < CNT_MAX);
        if (rd_en && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!rd_en || (cnt_d == CNT_MAX)) begin
          state_d = ST_TAIL;
        end
      end
      ST_TAIL: begin
        // Grant stays visible this cycle while the last strobe goes out.
        grant_d = '0;
        ptr_d   = (gidx_q == IDX_LAST) ? '0 : gidx_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scheduler state; reset aborts any burst in progress and restarts arbitration at index 0.
  always_ff @(posedge RClk or posedge PresetFull) begin
    if (PresetFull) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Data strobe goes to whoever owned the port when the read was issued, one cycle later.
  always_ff @(posedge RClk or posedge PresetFull) begin
    if (PresetFull) begin
      valid_q <= '0;
    end else begin
      valid_q <= rd_en ? grant_q : '0;
    end
  end

  assign Fifo_ReadEn = rd_en;
  assign Grant_out   = grant_q;
  assign Valid_out   = valid_q;
  assign Data_out    = Fifo_Data;

endmodule

// File: tb/tb_afifo_rd_sched.sv
// Scoreboard bench for afifo_rd_sched: a transaction-level model predicts grants and deliveries,
// a monitor compares them as the DUT presents them, and a queue-backed FIFO feeds read data.
// Directed cases cover the burst split, round-robin order, empty exit, request drop and mid-burst reset.
module tb_afifo_rd_sched;

  localparam int DW   = 8;
  localparam int NREQ = 4;
  localparam int MAXB = 4;

  typedef struct { int idx; int len; } gnt_t;
  typedef struct { int cons; logic [DW-1:0] dat; } dlv_t;

  logic            RClk = 1'b0;
  logic            PresetFull;
  logic            Fifo_Empty;
  logic [DW-1:0]   Fifo_Data;
  logic            Fifo_ReadEn;
  logic [NREQ-1:0] Req_in;
  logic [NREQ-1:0] Grant_out;
  logic [NREQ-1:0] Valid_out;
  logic [DW-1:0]   Data_out;

  logic [DW-1:0]   mem [0:1023];
  int              wr_ptr = 0;
  int              rd_ptr = 0;

  int              n_cmp = 0;
  int              n_err = 0;
  int              mptr  = 0;
  logic [DW-1:0]   mwords [$];
  gnt_t            exp_gnt [$];
  dlv_t            exp_dlv [$];

  always #5 RClk = ~RClk;

  assign Fifo_Empty = (wr_ptr == rd_ptr);

  afifo_rd_sched #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NREQ),
    .MAX_BURST  (MAXB)
  ) dut (
    .RClk        (RClk),
    .PresetFull  (PresetFull),
    .Fifo_Empty  (Fifo_Empty),
    .Fifo_Data   (Fifo_Data),
    .Fifo_ReadEn (Fifo_ReadEn),
    .Req_in      (Req_in),
    .Grant_out   (Grant_out),
    .Valid_out   (Valid_out),
    .Data_out    (Data_out)
  );

  // FIFO read side: an accepted read returns its word on the following cycle.
  always @(posedge RClk) begin
    if (Fifo_ReadEn && (rd_ptr != wr_ptr)) begin
      Fifo_Data <= mem[rd_ptr % 1024];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_words(input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = DW'($urandom_range(0, 255));
      mem[wr_ptr % 1024] = d;
      wr_ptr = wr_ptr + 1;
      mwords.push_back(d);
    end
  endtask

  // One expected grant to consumer c, followed by k words delivered to it in FIFO order.
  task automatic push_burst(input int c, input int k, input int len);
    dlv_t d;
    exp_gnt.push_back('{idx: c, len: len});
    for (int i = 0; i < k; i++) begin
      d.cons = c;
      d.dat  = mwords.pop_front();
      exp_dlv.push_back(d);
    end
  endtask

  // Steady requests: owners rotate from the pointer, each taking up to MAXB words until the FIFO is empty.
  task automatic model_run(input logic [NREQ-1:0] req);
    int c;
    int k;
    while ((mwords.size() > 0) && (req != '0)) begin
      c = mptr;
      while (((req >> c) & 4'b0001) == 4'b0000) c = (c + 1) % NREQ;
      k = (mwords.size() < MAXB) ? mwords.size() : MAXB;
      push_burst(c, k, k);
      mptr = (c + 1) % NREQ;
    end
  endtask

  task automatic wait_reads(input int want, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge RClk);
      if (Fifo_ReadEn === 1'b1) n++;
      if (n >= want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge RClk);
      if ((exp_dlv.size() == 0) && (exp_gnt.size() == 0)) begin
        done = 1'b1;
        break;
      end
    end
    chk({name, "_drained"}, done, 1);
    Req_in = '0;
    repeat (4) @(negedge RClk);
  endtask

  // Monitor: compares every grant, read and strobe the DUT presents against the expected queues.
  initial begin : monitor
    logic [NREQ-1:0] prev_gnt;
    logic [NREQ-1:0] one;
    int              rd_cnt;
    int              cur_len;
    int              vidx;
    gnt_t            g;
    dlv_t            d;
    prev_gnt = '0;
    one      = 1;
    rd_cnt   = 0;
    cur_len  = 0;
    forever begin
      @(negedge RClk or posedge PresetFull);
      if (PresetFull === 1'b1) begin
        #1;
        chk("rst_grant", Grant_out, 0);
        chk("rst_valid", Valid_out, 0);
        chk("rst_readen", Fifo_ReadEn, 0);
        prev_gnt = '0;
      end else begin
        if ((prev_gnt == '0) && (Grant_out != '0)) begin
          if (exp_gnt.size() == 0) begin
            chk("grant_unexpected", Grant_out, 0);
          end else begin
            g = exp_gnt.pop_front();
            chk("grant_owner", Grant_out, one << g.idx);
            cur_len = g.len;
          end
          rd_cnt = 0;
        end
        if (Fifo_ReadEn === 1'b1) begin
          rd_cnt++;
          chk("read_while_empty", Fifo_Empty, 0);
          chk("read_without_grant", (Grant_out != '0), 1);
        end
        if ((prev_gnt != '0) && (Grant_out == '0)) begin
          chk("burst_len", rd_cnt, cur_len);
        end
        if (Valid_out != '0) begin
          chk("valid_onehot", $onehot(Valid_out), 1);
          if (exp_dlv.size() == 0) begin
            chk("valid_unexpected", Valid_out, 0);
          end else begin
            d    = exp_dlv.pop_front();
            vidx = -1;
            for (int i = 0; i < NREQ; i++) if (Valid_out[i]) vidx = i;
            chk("valid_owner", vidx, d.cons);
            chk("valid_data", Data_out, d.dat);
          end
        end
        prev_gnt = Grant_out;
      end
    end
  end

  initial begin : main
    bit              ok;
    logic [NREQ-1:0] r;

    // Reset held with a requester and a non-empty FIFO: nothing may move.
    PresetFull = 1'b1;
    Req_in     = '1;
    load_words(1);
    repeat (3) @(negedge RClk);
    Req_in = '0;
    #2 PresetFull = 1'b0;
    @(negedge RClk);

    // All four requesting, 20 words: grants 0,1,2,3,0 with four reads each.
    load_words(19);
    model_run(4'b1111);
    Req_in = 4'b1111;
    wait_drain("rr_all");

    // Single requester, 6 words: a full burst of 4, then a burst of 2.
    load_words(6);
    model_run(4'b0001);
    Req_in = 4'b0001;
    wait_drain("single_6");

    // Two words only: burst ends when the FIFO runs empty.
    load_words(2);
    model_run(4'b0100);
    Req_in = 4'b0100;
    wait_drain("empty_exit");

    // Owner drops its request right after the second read.
    load_words(5);
    push_burst(1, 2, 2);
    mptr   = 2;
    Req_in = 4'b0010;
    wait_reads(2, ok);
    chk("drop_reads_seen", ok, 1);
    @(posedge RClk);
    #1 Req_in = '0;
    wait_drain("drop");
    model_run(4'b0111);
    Req_in = 4'b0111;
    wait_drain("after_drop");

    // Reset during the third read of a burst; arbitration restarts at index 0.
    load_words(6);
    push_burst(2, 2, 0);
    Req_in = 4'b0100;
    wait_reads(2, ok);
    chk("rst_reads_seen", ok, 1);
    @(posedge RClk);
    #7;
    PresetFull = 1'b1;
    Req_in     = '0;
    mptr       = 0;
    repeat (2) @(negedge RClk);
    #2 PresetFull = 1'b0;
    repeat (6) @(negedge RClk);
    chk("rst_pending_dlv", exp_dlv.size(), 0);
    chk("rst_fifo_words", wr_ptr - rd_ptr, mwords.size());
    model_run(4'b1010);
    Req_in = 4'b1010;
    wait_drain("after_rst");

    // Random word counts and request patterns.
    for (int it = 0; it < 25; it++) begin
      load_words($urandom_range(1, 12));
      r = NREQ'($urandom_range(1, 15));
      model_run(r);
      Req_in = r;
      wait_drain("rand");
    end

    chk("left_grants", exp_gnt.size(), 0);
    chk("left_dlv", exp_dlv.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: run did not complete, compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/afifo_rd_sched.md
AFIFO_RD_SCHED -- requirements
Module: afifo_rd_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the FIFO read data.
REQ-002 SHALL have parameter NUM_REQ, default 4: number of consumers sharing the FIFO read port (range 2..8).
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum number of reads issued per grant (range 1..16).
REQ-004 SHALL have port RClk, input, 1 bit: FIFO read-side clock; all logic on posedge.
REQ-005 SHALL have port PresetFull, input, 1 bit: reset, asynchronous, active-high; clock RClk.
REQ-006 SHALL have port Fifo_Empty, input, 1 bit: FIFO empty flag.
REQ-007 SHALL have port Fifo_Data, input, DATA_WIDTH bits: FIFO read data, valid one cycle after an accepted read.
REQ-008 SHALL have port Fifo_ReadEn, output, 1 bit: FIFO read enable.
REQ-009 SHALL have port Req_in, input, NUM_REQ bits: per-consumer read request, level-sensitive.
REQ-010 SHALL have port Grant_out, output, NUM_REQ bits: one-hot current owner of the read port, registered.
REQ-011 SHALL have port Valid_out, output, NUM_REQ bits: per-consumer data strobe, registered, at most one bit high.
REQ-012 SHALL have port Data_out, output, DATA_WIDTH bits: Fifo_Data passed through unregistered, qualified by Valid_out.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BURST, TAIL.
REQ-014 In IDLE, if Fifo_Empty=0 and Req_in!=0, the block SHALL select the first requester at or after the round-robin pointer (wrapping at NUM_REQ), load Grant_out, clear the burst counter, and enter BURST on the next edge.
REQ-015 In IDLE, Grant_out SHALL be 0, and Fifo_ReadEn SHALL be 0.
REQ-016 In BURST, Fifo_ReadEn SHALL equal the combinational expression: not Fifo_Empty, and the granted requester's Req_in bit high, and burst count < MAX_BURST.
REQ-017 Fifo_ReadEn SHALL never be high while Fifo_Empty=1, in any state.
REQ-018 The burst counter (width clog2(MAX_BURST+1)) SHALL increment on each cycle Fifo_ReadEn=1 and SHALL saturate at MAX_BURST.
REQ-019 BURST SHALL exit to TAIL on the cycle Fifo_ReadEn=0, or on the cycle the counter reaches MAX_BURST.
REQ-020 In TAIL, the block SHALL hold Grant_out and Fifo_ReadEn=0 for exactly one cycle, then enter IDLE with Grant_out=0.
REQ-021 When leaving TAIL, the round-robin pointer SHALL advance to (granted index + 1) mod NUM_REQ.
REQ-022 Valid_out SHALL equal Grant_out registered, ANDed with Fifo_ReadEn registered; latency from the read to the strobe is 1 cycle.
REQ-023 Every accepted read SHALL produce exactly one Valid_out pulse, to the consumer that owned the grant when the read was issued, including the last read of a burst (emitted in TAIL).
REQ-024 A requester dropping Req_in mid-burst SHALL stop further reads the same cycle; reads already issued SHALL still be delivered.
REQ-025 Minimum gap between grants SHALL be one IDLE cycle; requests arriving during BURST/TAIL wait for IDLE arbitration.

Reset
REQ-026 While PresetFull=1: state=IDLE, Grant_out=0, Valid_out=0, Fifo_ReadEn=0, burst counter=0, round-robin pointer=0.
REQ-027 Assertion of PresetFull mid-burst SHALL abort the burst immediately with no further Valid_out pulses; the first arbitration after deassertion starts from index 0.

Structure
REQ-028 The FSM state enum, the clog2 helper function, and the NUM_REQ/MAX_BURST defaults SHALL reside in shared package afifo_pkg.
REQ-029 Round-robin selection (request vector plus pointer in, one-hot out) SHALL be a combinational sub-module named rr_arbiter; all sequencing logic SHALL stay in afifo_rd_sched.

Verification
REQ-030 Bench SHALL cover: Req_in=0001, FIFO holding 6 words, MAX_BURST=4 -> 4 ReadEn cycles, TAIL, IDLE, then 2 ReadEn cycles; Valid_out[0] pulses 6 times with data in FIFO order.
REQ-031 Bench SHALL cover: Req_in=1111, FIFO kept non-empty -> grant sequence 0,1,2,3,0, each grant a 4-read burst.
REQ-032 Bench SHALL cover: Req_in=0100, FIFO holding 2 words -> ReadEn for 2 cycles, exit on Fifo_Empty=1, 2 pulses on Valid_out[2], no read while empty.
REQ-033 Bench SHALL cover: Req_in[1] dropped after 2nd read -> ReadEn stops that cycle, 2 pulses on Valid_out[1], pointer advances to 2.
REQ-034 Bench SHALL cover: PresetFull pulsed during the 3rd read of a burst -> outputs 0 asynchronously, no Valid_out afterwards; next grant goes to the lowest requesting index.
